// File: rtl/fpmul_ctrl_pkg.sv
// Shared state encoding for the floating-point multiplier control FSM.
package fpmul_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE                  = 2'd0;
    localparam state_t CHECK_SHIFT_INCREMENT = 2'd1;
    localparam state_t ROUND                 = 2'd2;
    localparam state_t ILLEGAL               = 2'd3;

    // Loop counter width; a zero-width counter is not legal, so clamp to one bit.
    function automatic int renormCntWidth(input int maxRenorm);
        int w;
        w = $clog2(maxRenorm + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/control_floating_point_mul.sv
// Control FSM sequencing normalise / exponent-increment / round for the FP multiplier datapath.
// Optional FPMUL_CTRL_DONE_EN adds a registered one-cycle 'done' pulse after each completed operation.
module control_floating_point_mul
    import fpmul_ctrl_pkg::*;
#(
    parameter int MAX_RENORM = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic MLB_significand_mult,
    input  logic MLB_exponent_inc,
    output logic inc_shift_en,
    output logic mux_en_rounding,
    output logic mux_en_reg,
    output logic enable_reg,
    output logic enable_rounding
`ifdef FPMUL_CTRL_DONE_EN
    ,
    output logic done
`endif
);

    localparam int CNT_W = renormCntWidth(MAX_RENORM);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RENORM);

    state_t           current_state_q, current_state_d;
    logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
    logic             renorm_take;
    logic             op_finish;

    // A rounding overflow loops back only while the renormalise budget lasts.
    assign renorm_take = (current_state_q == ROUND) && MLB_exponent_inc && (loop_cnt_q < CNT_MAX);
    assign op_finish   = (current_state_q == ROUND) && !renorm_take;

    always_comb begin
        current_state_d = IDLE;
        loop_cnt_d      = loop_cnt_q;
        case (current_state_q)
            IDLE: begin
                current_state_d = CHECK_SHIFT_INCREMENT;
                loop_cnt_d      = '0;
            end
            CHECK_SHIFT_INCREMENT: begin
                current_state_d = ROUND;
            end
            ROUND: begin
                if (renorm_take) begin
                    current_state_d = CHECK_SHIFT_INCREMENT;
                    loop_cnt_d      = loop_cnt_q + 1'b1;
                end else begin
                    current_state_d = IDLE;
                    loop_cnt_d      = '0;
                end
            end
            default: begin
                current_state_d = IDLE;
                loop_cnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_state_q <= IDLE;
            loop_cnt_q      <= '0;
        end else begin
            current_state_q <= current_state_d;
            loop_cnt_q      <= loop_cnt_d;
        end
    end

`ifdef FPMUL_CTRL_DONE_EN
    logic done_q, done_d;

    assign done_d = op_finish;

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`else
    logic unused_finish;
    assign unused_finish = op_finish;
`endif

    // Outputs are forced low during reset so nothing in the datapath moves.
    always_comb begin
        inc_shift_en    = 1'b0;
        mux_en_rounding = 1'b0;
        mux_en_reg      = 1'b0;
        enable_reg      = 1'b0;
        enable_rounding = 1'b0;
        if (!reset) begin
            case (current_state_q)
                IDLE: begin
                    enable_reg = 1'b1;
                end
                CHECK_SHIFT_INCREMENT: begin
                    inc_shift_en = MLB_significand_mult;
                    enable_reg   = MLB_significand_mult;
                    mux_en_reg   = 1'b1;
                end
                ROUND: begin
                    enable_rounding = 1'b1;
                    mux_en_rounding = 1'b1;
                    mux_en_reg      = 1'b1;
                    enable_reg      = 1'b1;
                end
                default: begin
                    enable_reg = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_floating_point_mul.sv
// Self-checking bench for control_floating_point_mul: directed steps then random inputs vs. a phase-level model.
// Define FPMUL_CTRL_DONE_EN to also check the done pulse.
module tb_control_floating_point_mul;

    localparam int MAXR = 1;

    logic clk;
    logic reset;
    logic sigMsb;
    logic expMsb;
    logic incShiftEn, muxEnRounding, muxEnReg, enableReg, enableRounding;
`ifdef FPMUL_CTRL_DONE_EN
    logic done;
`endif

    int total;
    int bad;

    // Reference: phase 0 = load product, 1 = normalise, 2 = round; loops = renormalisations used.
    int mdlPhase;
    int mdlLoops;
    bit mdlDone;
    bit mdlKnown;

    control_floating_point_mul #(.MAX_RENORM(MAXR)) dut (
        .clk                 (clk),
        .reset               (reset),
        .MLB_significand_mult(sigMsb),
        .MLB_exponent_inc    (expMsb),
        .inc_shift_en        (incShiftEn),
        .mux_en_rounding     (muxEnRounding),
        .mux_en_reg          (muxEnReg),
        .enable_reg          (enableReg),
        .enable_rounding     (enableRounding)
`ifdef FPMUL_CTRL_DONE_EN
        ,
        .done                (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareBit(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0b expected=%0b phase=%0d t=%0t", tag, observed, expected, mdlPhase, $time);
        end
    endtask

    task automatic checkOutput();
        bit eInc, eMr, eMreg, eEreg, eEr;
        eInc = 0; eMr = 0; eMreg = 0; eEreg = 0; eEr = 0;
        if (!reset) begin
            if (mdlPhase == 0) begin
                eEreg = 1;
            end else if (mdlPhase == 1) begin
                eInc  = sigMsb;
                eEreg = sigMsb;
                eMreg = 1;
            end else begin
                eEr = 1; eMr = 1; eMreg = 1; eEreg = 1;
            end
        end
        compareBit("inc_shift_en", incShiftEn, eInc);
        compareBit("mux_en_rounding", muxEnRounding, eMr);
        compareBit("mux_en_reg", muxEnReg, eMreg);
        compareBit("enable_reg", enableReg, eEreg);
        compareBit("enable_rounding", enableRounding, eEr);
`ifdef FPMUL_CTRL_DONE_EN
        if (mdlKnown) compareBit("done", done, mdlDone);
`endif
    endtask

    task automatic modelEdge();
        mdlKnown = 1;
        mdlDone  = 0;
        if (reset) begin
            mdlPhase = 0;
            mdlLoops = 0;
        end else if (mdlPhase == 0) begin
            mdlPhase = 1;
            mdlLoops = 0;
        end else if (mdlPhase == 1) begin
            mdlPhase = 2;
        end else if (expMsb && mdlLoops < MAXR) begin
            mdlPhase = 1;
            mdlLoops = mdlLoops + 1;
        end else begin
            mdlPhase = 0;
            mdlLoops = 0;
            mdlDone  = 1;
        end
    endtask

    // Drive one cycle's inputs, check mid-cycle, then advance the model across the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic e);
        reset  = r;
        sigMsb = s;
        expMsb = e;
        #1;
        checkOutput();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mdlPhase = 0;
        mdlLoops = 0;
        mdlDone  = 0;
        mdlKnown = 0;

        // Reset for one cycle, then a plain pass: IDLE, CHECK, ROUND, IDLE.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);

        // Significand MSB set in CHECK and outside it.
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);

        // Rounding overflow: one loop-back, then second overflow exits.
        applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);

        // Reset asserted while in ROUND, then recovery.
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 1, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
